shr_pipe: RTL and testbench

SHR_PIPE -- requirements
Module: shr_pipe

---
 rtl/spu_fx2_pkg.sv | 31 +++
 rtl/shr_pipe_if.sv | 24 ++
 rtl/shr_word.sv | 14 +
 rtl/shr_pipe.sv | 137 +++++++++++++
 tb/tb_shr_pipe.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/spu_fx2_pkg.sv
// Shared definitions for the FX2 shift pipe: opcodes, latency and the
// 32-bit big-endian word shifter used by every shift stage.
package spu_fx2_pkg;

    localparam int FX2_LATENCY = 4;
    localparam int FX2_WORDS   = 4;

    typedef enum logic [1:0] {
        OP_ROTM  = 2'b00,
        OP_ROTMA = 2'b01,
        OP_ROTMI = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    // Move each bit from index b to index b+count (bit 0 is the MSB), filling
    // the vacated high-order bits with zero or, when arith is set, the word's bit 0.
    function automatic logic [0:31] shr32(input logic [0:31] word,
                                          input logic [5:0]  count,
                                          input logic        arith);
        logic [0:31] fill;
        logic [0:31] res;
        fill = {32{arith & word[0]}};
        if (count >= 6'd32) begin
            res = fill;
        end else begin
            res = (word >> count) | (fill & ~(32'hFFFF_FFFF >> count));
        end
        return res;
    endfunction

endpackage

// File: rtl/shr_pipe_if.sv
// Issue/result bundle of the shift pipe. The issuing unit uses the master
// modport, the pipe itself the slave modport.
interface shr_pipe_if;
    logic         in_valid;
    logic [1:0]   in_op;
    logic [0:127] in_ra;
    logic [0:127] in_rb;
    logic [6:0]   in_imm;
    logic [6:0]   in_rt;
    logic         flush;
    logic         out_valid;
    logic [6:0]   out_rt;
    logic [0:127] out_result;

    modport master (
        output in_valid, in_op, in_ra, in_rb, in_imm, in_rt, flush,
        input  out_valid, out_rt, out_result
    );

    modport slave (
        input  in_valid, in_op, in_ra, in_rb, in_imm, in_rt, flush,
        output out_valid, out_rt, out_result
    );
endinterface

// File: rtl/shr_word.sv
// Combinational 32-bit right shifter (big-endian bit numbering) with
// optional sign fill. A count of 32 or more yields all fill bits.
module shr_word
    import spu_fx2_pkg::*;
(
    input  logic [0:31] word,
    input  logic [5:0]  count,
    input  logic        arith,
    output logic [0:31] result
);

    assign result = shr32(word, count, arith);

endmodule

// File: rtl/shr_pipe.sv
// Four-stage quadword shift pipe (ROTM / ROTMA / ROTMI).
//   S1: count decode  S2: coarse shift by s[5:4]  S3: fine shift by s[3:0]
//   S4: output register
// Optional feature: define SHR_PIPE_ROTMA_EN to enable the sign-filling
// ROTMA operation; without it op 01 behaves as the reserved opcode.
module shr_pipe
    import spu_fx2_pkg::*;
#(
    parameter int LATENCY = FX2_LATENCY
)
(
    input  logic       clk,
    input  logic       rst_n,
    shr_pipe_if.slave  bus
);

    localparam int NW = FX2_WORDS;

    op_e          op_s;
    logic         arith_s;
    logic         zero_s;
    logic [5:0]   cnt_s [NW];
    logic [0:127] ra_s;

    logic [LATENCY-1:0] vld_r;

    logic [0:127] s1_ra_r;
    logic [5:0]   s1_cnt_r [NW];
    logic         s1_arith_r;
    logic [6:0]   s1_rt_r;

    logic [0:31]  coarse_s [NW];
    logic [0:127] s2_data_r;
    logic [3:0]   s2_fine_r [NW];
    logic         s2_arith_r;
    logic [6:0]   s2_rt_r;

    logic [0:127] fine_s;
    logic [0:127] s3_data_r;
    logic [6:0]   s3_rt_r;

    logic [6:0]   out_rt_r;
    logic [0:127] out_result_r;

    // Only the low six bits of each count word (and of the sign-extended
    // immediate) can influence s, so the remaining bits are intentionally dropped.
    logic unused_s;
    assign unused_s = ^{bus.in_rb[0:25], bus.in_rb[32:57], bus.in_rb[64:89],
                        bus.in_rb[96:121], bus.in_imm[6]};

    // S1 decode: opcode to fill mode / zero result, per-word count s = -c mod 64
    always_comb begin
        op_s    = op_e'(bus.in_op);
        arith_s = 1'b0;
        zero_s  = 1'b0;
        case (op_s)
            OP_ROTM:  zero_s = 1'b0;
`ifdef SHR_PIPE_ROTMA_EN
            OP_ROTMA: arith_s = 1'b1;
`else
            OP_ROTMA: zero_s = 1'b1;
`endif
            OP_ROTMI: zero_s = 1'b0;
            OP_RSVD:  zero_s = 1'b1;
            default:  zero_s = 1'b1;
        endcase
        for (int w = 0; w < NW; w++) begin
            cnt_s[w] = (op_s == OP_ROTMI) ? (6'd0 - bus.in_imm[5:0])
                                          : (6'd0 - bus.in_rb[w*32+26 +: 6]);
        end
        ra_s = zero_s ? 128'd0 : bus.in_ra;
    end

    // Stage valid chain: reset or flush empties every stage at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_r <= {LATENCY{1'b0}};
        end else if (bus.flush) begin
            vld_r <= {LATENCY{1'b0}};
        end else begin
            vld_r <= {vld_r[LATENCY-2:0], bus.in_valid};
        end
    end

    // S2 coarse shift: 0/16/32/48 bit positions per word
    for (genvar g = 0; g < NW; g++) begin : g_word
        shr_word u_word (
            .word   (s1_ra_r[g*32 +: 32]),
            .count  ({s1_cnt_r[g][5:4], 4'b0000}),
            .arith  (s1_arith_r),
            .result (coarse_s[g])
        );
    end

    // S3 fine shift: remaining 0..15 positions; bit 0 still holds the original sign
    always_comb begin
        fine_s = 128'd0;
        for (int w = 0; w < NW; w++) begin
            fine_s[w*32 +: 32] = shr32(s2_data_r[w*32 +: 32], {2'b00, s2_fine_r[w]}, s2_arith_r);
        end
    end

    // Stage data registers: follow the valid chain without needing a reset
    always_ff @(posedge clk) begin
        s1_ra_r    <= ra_s;
        s1_cnt_r   <= cnt_s;
        s1_arith_r <= arith_s;
        s1_rt_r    <= bus.in_rt;
        for (int w = 0; w < NW; w++) begin
            s2_data_r[w*32 +: 32] <= coarse_s[w];
            s2_fine_r[w]          <= s1_cnt_r[w][3:0];
        end
        s2_arith_r <= s1_arith_r;
        s2_rt_r    <= s1_rt_r;
        s3_data_r  <= fine_s;
        s3_rt_r    <= s2_rt_r;
    end

    // S4 output register: loads only with a surviving result, otherwise holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_rt_r     <= 7'd0;
            out_result_r <= 128'd0;
        end else if (vld_r[LATENCY-2] && !bus.flush) begin
            out_rt_r     <= s3_rt_r;
            out_result_r <= s3_data_r;
        end else begin
            out_rt_r     <= out_rt_r;
            out_result_r <= out_result_r;
        end
    end

    assign bus.out_valid  = vld_r[LATENCY-1];
    assign bus.out_rt     = out_rt_r;
    assign bus.out_result = out_result_r;

endmodule

// File: tb/tb_shr_pipe.sv
// Directed bench for shr_pipe: vector table for the shift function plus
// hand-written back-to-back, flush and mid-flight reset sequences.
// Expectations for op 01 follow SHR_PIPE_ROTMA_EN.
module tb_shr_pipe;
    import spu_fx2_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    shr_pipe_if bus();

    shr_pipe #(.LATENCY(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

`ifdef SHR_PIPE_ROTMA_EN
    localparam bit ROTMA_ON = 1'b1;
`else
    localparam bit ROTMA_ON = 1'b0;
`endif

    typedef struct {
        logic [1:0]   op;
        logic [127:0] ra;
        logic [127:0] rb;
        logic [6:0]   imm;
        logic [6:0]   rt;
        logic [127:0] exp;
    } vec_t;

    vec_t vecs [12];

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] bb_rb [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFC};
    logic [31:0] bb_ex [4] = '{32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0800_0000};

    function automatic logic [127:0] rep(input logic [31:0] w);
        return {4{w}};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [127:0] ra,
                         input logic [127:0] rb, input logic [6:0] imm, input logic [6:0] rt);
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_ra    = ra;
        bus.in_rb    = rb;
        bus.in_imm   = imm;
        bus.in_rt    = rt;
    endtask

    initial begin
        vecs[0]  = '{2'b00, rep(32'h8000_0000), rep(32'hFFFF_FFFC), 7'd0, 7'd5, rep(32'h0800_0000)};
        vecs[1]  = '{2'b01, rep(32'h8000_0000), rep(32'hFFFF_FFFC), 7'd0, 7'd6,
                     ROTMA_ON ? rep(32'hF800_0000) : 128'd0};
        vecs[2]  = '{2'b01, rep(32'h8000_0000), rep(32'hFFFF_FFE0), 7'd0, 7'd7,
                     ROTMA_ON ? rep(32'hFFFF_FFFF) : 128'd0};
        vecs[3]  = '{2'b00, rep(32'h8000_0000), rep(32'hFFFF_FFE0), 7'd0, 7'd8, 128'd0};
        vecs[4]  = '{2'b00, rep(32'h1234_5678), rep(32'h0000_0040), 7'd0, 7'd9, rep(32'h1234_5678)};
        vecs[5]  = '{2'b10, rep(32'h1234_5678), rep(32'hFFFF_FFFC), 7'd0, 7'd10, rep(32'h1234_5678)};
        vecs[6]  = '{2'b10, {32'h1234_5678, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001}, 128'd0,
                     7'h7F, 7'd11, {32'h091A_2B3C, 32'h4000_0000, 32'h7FFF_FFFF, 32'h0000_0000}};
        vecs[7]  = '{2'b10, {32'h1234_5678, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001}, 128'd0,
                     7'h78, 7'd12, {32'h0012_3456, 32'h0080_0000, 32'h00FF_FFFF, 32'h0000_0000}};
        vecs[8]  = '{2'b00, rep(32'hF0F0_F0F0),
                     {32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'hFFFF_FFE1, 32'h0000_0000}, 7'd0, 7'd13,
                     {32'h7878_7878, 32'h0000_F0F0, 32'h0000_0001, 32'hF0F0_F0F0}};
        vecs[9]  = '{2'b01, rep(32'hF0F0_F0F0),
                     {32'hFFFF_FFFF, 32'hFFFF_FFF0, 32'hFFFF_FFE1, 32'h0000_0000}, 7'd0, 7'd14,
                     ROTMA_ON ? {32'hF878_7878, 32'hFFFF_F0F0, 32'hFFFF_FFFF, 32'hF0F0_F0F0} : 128'd0};
        vecs[10] = '{2'b11, rep(32'h1234_5678), 128'd0, 7'd0, 7'd15, 128'd0};
        vecs[11] = '{2'b00, rep(32'h8000_0001),
                     {32'h0000_003F, 32'h0000_001F, 32'h0000_0021, 32'h0000_0020}, 7'd0, 7'd16,
                     {32'h4000_0000, 32'h0000_0000, 32'h0000_0001, 32'h0000_0000}};

        bus.flush = 1'b0;
        drive(1'b0, 2'b00, 128'd0, 128'd0, 7'd0, 7'd0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset out_valid", {127'd0, bus.out_valid}, 128'd1 - 128'd1);
        chk("reset out_rt", {121'd0, bus.out_rt}, 128'd0);
        chk("reset out_result", bus.out_result, 128'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle out_valid", {127'd0, bus.out_valid}, 128'd0);

        // Vector table: one issue, nothing early, result at exactly 4 cycles
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(1'b1, vecs[i].op, vecs[i].ra, vecs[i].rb, vecs[i].imm, vecs[i].rt);
            @(negedge clk);
            bus.in_valid = 1'b0;
            repeat (2) @(negedge clk);
            chk($sformatf("vec%0d early valid", i), {127'd0, bus.out_valid}, 128'd0);
            @(negedge clk);
            chk($sformatf("vec%0d valid", i), {127'd0, bus.out_valid}, 128'd1);
            chk($sformatf("vec%0d rt", i), {121'd0, bus.out_rt}, {121'd0, vecs[i].rt});
            chk($sformatf("vec%0d result", i), bus.out_result, vecs[i].exp);
        end

        // Back-to-back issues with tags 1..4
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1'b1, 2'b00, rep(32'h8000_0000), rep(bb_rb[k]), 7'd0, 7'(k + 1));
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) bus.in_valid = 1'b0;
            chk($sformatf("b2b%0d valid", k), {127'd0, bus.out_valid}, 128'd1);
            chk($sformatf("b2b%0d rt", k), {121'd0, bus.out_rt}, 128'(k + 1));
            chk($sformatf("b2b%0d result", k), bus.out_result, rep(bb_ex[k]));
        end
        @(negedge clk);
        chk("b2b tail valid", {127'd0, bus.out_valid}, 128'd0);

        // Flush two cycles after an issue; an issue coinciding with flush is
        // dropped; an issue on the next cycle completes normally
        @(negedge clk);                                   // N0
        drive(1'b1, 2'b00, rep(32'h1234_5678), 128'd0, 7'd0, 7'd9);
        @(negedge clk);                                   // N1
        bus.in_valid = 1'b0;
        @(negedge clk);                                   // N2
        drive(1'b1, 2'b00, rep(32'h1234_5678), 128'd0, 7'd0, 7'd11);
        bus.flush = 1'b1;
        @(negedge clk);                                   // N3
        bus.flush = 1'b0;
        drive(1'b1, 2'b10, rep(32'h1234_5678), 128'd0, 7'h7C, 7'd10);
        chk("flush next valid", {127'd0, bus.out_valid}, 128'd0);
        for (int n = 4; n < 7; n++) begin
            @(negedge clk);                               // N4..N6
            bus.in_valid = 1'b0;
            chk($sformatf("flush N%0d valid", n), {127'd0, bus.out_valid}, 128'd0);
            chk($sformatf("flush N%0d rt hold", n), {121'd0, bus.out_rt}, 128'd4);
            chk($sformatf("flush N%0d result hold", n), bus.out_result, rep(32'h0800_0000));
        end
        @(negedge clk);                                   // N7
        chk("post-flush valid", {127'd0, bus.out_valid}, 128'd1);
        chk("post-flush rt", {121'd0, bus.out_rt}, 128'd10);
        chk("post-flush result", bus.out_result, rep(32'h0123_4567));

        // Reset mid-flight
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1'b1, 2'b00, rep(32'h8000_0000), rep(32'hFFFF_FFFC), 7'd0, 7'(20 + k));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("pre-reset valid", {127'd0, bus.out_valid}, 128'd1);
        chk("pre-reset rt", {121'd0, bus.out_rt}, 128'd20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset async valid", {127'd0, bus.out_valid}, 128'd0);
        chk("reset async rt", {121'd0, bus.out_rt}, 128'd0);
        chk("reset async result", bus.out_result, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            chk($sformatf("reset drain%0d valid", n), {127'd0, bus.out_valid}, 128'd0);
            @(negedge clk);
        end
        drive(1'b1, 2'b10, rep(32'hF000_0000), 128'd0, 7'h7E, 7'd30);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("after-reset early valid", {127'd0, bus.out_valid}, 128'd0);
        @(negedge clk);
        chk("after-reset valid", {127'd0, bus.out_valid}, 128'd1);
        chk("after-reset rt", {121'd0, bus.out_rt}, 128'd30);
        chk("after-reset result", bus.out_result, rep(32'h3C00_0000));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
